// File: rtl/xif_result_buffer.sv
// In-order result FIFO feeding the CORE-V-XIF result channel; tracks busy IDs, flags duplicate pushes.
// Optional same-cycle bypass when empty is enabled by defining XIF_RESULT_BYPASS_EN.
module xif_result_buffer #(
  parameter int X_ID_WIDTH  = 4,
  parameter int X_RFW_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                         ck,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [X_ID_WIDTH-1:0]        in_id,
  input  logic [X_RFW_WIDTH-1:0]       in_data,
  input  logic [4:0]                   in_rd,
  output logic                         result_valid,
  input  logic                         result_ready,
  output logic [X_ID_WIDTH-1:0]        result_id,
  output logic [X_RFW_WIDTH-1:0]       result_data,
  output logic [4:0]                   result_rd,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [2**X_ID_WIDTH-1:0]     id_busy,
  output logic                         dup_err
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int NID = 2**X_ID_WIDTH;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [X_ID_WIDTH-1:0]  r_id_mem   [DEPTH];
  logic [X_RFW_WIDTH-1:0] r_data_mem [DEPTH];
  logic [4:0]             r_rd_mem   [DEPTH];
  logic [PW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic [NID-1:0]         r_id_busy;
  logic                   r_dup_err;

  logic                   w_byp, w_byp_take, w_push, w_pop, w_store, w_deq;
  logic [NID-1:0]         w_busy_nxt;

  assign in_ready = (r_count != FULL);
  assign count    = r_count;
  assign id_busy  = r_id_busy;
  assign dup_err  = r_dup_err;

`ifdef XIF_RESULT_BYPASS_EN
  assign w_byp        = (r_count == '0) & in_valid;
  assign result_valid = (r_count != '0) | w_byp;
  assign result_id    = w_byp ? in_id   : r_id_mem[r_rd_ptr];
  assign result_data  = w_byp ? in_data : r_data_mem[r_rd_ptr];
  assign result_rd    = w_byp ? in_rd   : r_rd_mem[r_rd_ptr];
`else
  assign w_byp        = 1'b0;
  assign result_valid = (r_count != '0);
  assign result_id    = r_id_mem[r_rd_ptr];
  assign result_data  = r_data_mem[r_rd_ptr];
  assign result_rd    = r_rd_mem[r_rd_ptr];
`endif

  assign w_push     = in_valid & in_ready;
  assign w_pop      = result_valid & result_ready;
  // A bypassed result consumed in the same cycle never touches storage.
  assign w_byp_take = w_byp & result_ready;
  assign w_store    = w_push & ~w_byp_take;
  assign w_deq      = w_pop & ~w_byp_take;

  always_comb begin
    w_busy_nxt = r_id_busy;
    if (w_deq)   w_busy_nxt[r_id_mem[r_rd_ptr]] = 1'b0;
    if (w_store) w_busy_nxt[in_id] = 1'b1;
  end

  always_ff @(posedge ck) begin
    if (w_store) begin
      r_id_mem[r_wr_ptr]   <= in_id;
      r_data_mem[r_wr_ptr] <= in_data;
      r_rd_mem[r_wr_ptr]   <= in_rd;
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_id_busy <= '0;
      r_dup_err <= 1'b0;
    end else begin
      if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq)   r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count   <= r_count + CW'(w_store) - CW'(w_deq);
      r_id_busy <= w_busy_nxt;
      if (w_push && r_id_busy[in_id]) r_dup_err <= 1'b1;
    end
  end
endmodule
